// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: requester-side and RAM-slave-side signal bundle for the round-robin RAM arbiter.
// The arbiter takes the slave modport; requesters and the RAM model take the master modport.
interface ram_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_rw;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_done;
    logic [NUM_REQ-1:0]    rsp_err;
    logic [31:0]           rsp_rdata;
    logic                  slv_cs;
    logic                  slv_rw;
    logic [15:0]           slv_addr;
    logic [31:0]           slv_wdata;
    logic                  slv_ready;
    logic [31:0]           slv_rdata;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, slv_ready, slv_rdata,
        output rsp_done, rsp_err, rsp_rdata, slv_cs, slv_rw, slv_addr, slv_wdata
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, slv_ready, slv_rdata,
        input  rsp_done, rsp_err, rsp_rdata, slv_cs, slv_rw, slv_addr, slv_wdata
    );
endinterface

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: round-robin arbiter sharing one cs/rw/ready RAM port among NUM_REQ requesters.
// Every output is registered; a transfer runs IDLE -> BUSY -> RELEASE with an optional BUSY timeout.
module ram_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    ram_bus_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      ptr, ptr_n, win, idx;
    logic               found, timeout;
    logic [TW-1:0]      timer, timer_n;
    logic               cs_n, rw_n;
    logic [15:0]        addr_n;
    logic [31:0]        wdata_n, rdata_n;
    logic [NUM_REQ-1:0] done_n, err_n;

    // First requesting index after the last winner, wrapping around
    always_comb begin
        found = 1'b0;
        win = ptr;
        idx = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    assign timeout = TIMEOUT_CYCLES != 0 && int'(timer) + 1 == TIMEOUT_CYCLES;

    always_comb begin
        state_n = state;
        ptr_n = ptr;
        timer_n = timer;
        cs_n = bus.slv_cs;
        rw_n = bus.slv_rw;
        addr_n = bus.slv_addr;
        wdata_n = bus.slv_wdata;
        done_n = '0;
        err_n = '0;
        rdata_n = '0;
        case (state)
            IDLE: if (found) begin
                state_n = BUSY;
                ptr_n = win;
                timer_n = '0;
                cs_n = 1'b1;
                rw_n = bus.req_rw[win];
                addr_n = bus.req_addr[16*win +: 16];
                wdata_n = bus.req_wdata[32*win +: 32];
            end
            BUSY: if (bus.slv_ready || timeout) begin
                state_n = RELEASE;
                cs_n = 1'b0;
                done_n[ptr] = 1'b1;
                err_n[ptr] = !bus.slv_ready;
                rdata_n = bus.slv_ready && bus.slv_rw ? bus.slv_rdata : '0;
            end else begin
                timer_n = timer + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= PW'(NUM_REQ - 1);
            timer <= '0;
            bus.slv_cs <= 1'b0;
            bus.slv_rw <= 1'b0;
            bus.slv_addr <= '0;
            bus.slv_wdata <= '0;
            bus.rsp_done <= '0;
            bus.rsp_err <= '0;
            bus.rsp_rdata <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            timer <= timer_n;
            bus.slv_cs <= cs_n;
            bus.slv_rw <= rw_n;
            bus.slv_addr <= addr_n;
            bus.slv_wdata <= wdata_n;
            bus.rsp_done <= done_n;
            bus.rsp_err <= err_n;
            bus.rsp_rdata <= rdata_n;
        end
    end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed and randomized transfers through the RAM arbiter, checked against
// a transaction-level model (distance-based round robin, word memory, fixed slave latency).
module tb_ram_bus_arbiter;
    localparam int N = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_bus_arbiter_if #(.NUM_REQ(N)) bus ();
    ram_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last, done_cyc, prev_done, w, w2;
    int waits [N];
    logic stall = 1'b0;
    logic s_ready, s_wait;
    logic [31:0] s_rdata, got, got2;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    assign bus.slv_ready = s_ready;
    assign bus.slv_rdata = s_rdata;

    function automatic logic [31:0] init_word(int i);
        return i == 4 ? 32'hDEADBEEF : 32'hC0DE_0000 | 32'(i);
    endfunction

    // RAM slave: one wait cycle after seeing cs, then ready for one cycle; stall keeps ready low
    always @(posedge clk) begin
        if (reset) begin
            s_ready <= 1'b0;
            s_wait <= 1'b0;
            s_rdata <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (!bus.slv_cs || stall) begin
            s_ready <= 1'b0;
            s_wait <= 1'b0;
        end else if (s_ready) begin
            s_ready <= 1'b0;
        end else if (s_wait) begin
            s_ready <= 1'b1;
            s_wait <= 1'b0;
            if (bus.slv_rw) s_rdata <= mem[bus.slv_addr[9:2]];
            else mem[bus.slv_addr[9:2]] <= bus.slv_wdata;
        end else begin
            s_wait <= 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic rw, input logic [15:0] a, input logic [31:0] d);
        bus.req_valid[i] = v;
        bus.req_rw[i] = rw;
        bus.req_addr[16*i +: 16] = a;
        bus.req_wdata[32*i +: 32] = d;
    endtask

    function automatic logic [15:0] rand_addr();
        return 16'($urandom_range(0, 15) << 2);
    endfunction

    // Winner = valid requester with the smallest distance past the previous winner
    function automatic int model_pick();
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && (i - last - 1 + N) % N < bd) begin
                bd = (i - last - 1 + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic model_reset();
        last = N - 1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        bus.req_valid = '0;
        bus.req_rw = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        tick();
        tick();
        check("reset_cs", 32'(bus.slv_cs), 0);
        check("reset_done", 32'(bus.rsp_done), 0);
        check("reset_err", 32'(bus.rsp_err), 0);
        check("reset_rdata", bus.rsp_rdata, 0);
        check("reset_addr", 32'(bus.slv_addr), 0);
        reset = 1'b0;
        model_reset();
    endtask

    // One complete transfer: grant, hold, done/err pulse, one-cycle release
    task automatic xfer(input logic stl, input logic disturb, output int wo, output logic [31:0] rd);
        int n = 0;
        logic stable = 1'b1;
        logic ew;
        logic [15:0] ea;
        logic [31:0] ed, er;
        stall = stl;
        wo = model_pick();
        if (wo < 0) wo = 0;
        ew = bus.req_rw[wo];
        ea = bus.req_addr[16*wo +: 16];
        ed = bus.req_wdata[32*wo +: 32];
        while (bus.slv_cs !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("grant_wait", 32'(n < 10), 1);
        check("slv_addr", 32'(bus.slv_addr), 32'(ea));
        check("slv_rw", 32'(bus.slv_rw), 32'(ew));
        check("slv_wdata", bus.slv_wdata, ed);
        for (int i = 0; i < N; i++) if (i != wo && bus.req_valid[i]) waits[i]++;
        check("fairness", 32'(waits[wo] <= N - 1), 1);
        waits[wo] = 0;
        if (disturb) begin
            bus.req_valid[wo] = 1'b0;
            bus.req_addr[16*wo +: 16] = ~ea;
        end
        n = 0;
        for (int t = 0; t < 40 && bus.rsp_done === '0; t++) begin
            n += int'(bus.slv_cs === 1'b1);
            if (bus.slv_addr !== ea) stable = 1'b0;
            tick();
        end
        done_cyc = cyc;
        er = (stl || !ew) ? 32'h0 : ref_mem[ea[9:2]];
        check("cs_cycles", 32'(n), stl ? 32'(TMO) : 32'd3);
        check("done", 32'(bus.rsp_done), 32'(1) << wo);
        check("err", 32'(bus.rsp_err), stl ? 32'(1) << wo : 32'h0);
        check("rdata", bus.rsp_rdata, er);
        check("cs_drop", 32'(bus.slv_cs), 0);
        check("addr_hold", 32'(stable), 1);
        rd = bus.rsp_rdata;
        if (!stl && !ew) ref_mem[ea[9:2]] = ed;
        last = wo;
        tick();
        check("release", 32'({bus.rsp_done, bus.rsp_err, bus.slv_cs}), 0);
    endtask

    initial begin
        do_reset();

        // Single read from requester 1
        set_req(1, 1'b1, 1'b1, 16'h0010, 32'h0);
        xfer(1'b0, 1'b0, w, got);
        check("t1_grant", 32'(w), 1);
        check("t1_rdata", got, 32'hDEADBEEF);
        bus.req_valid[1] = 1'b0;

        // Write from requester 0 then read it back through requester 2
        set_req(0, 1'b1, 1'b0, 16'h0020, 32'h12345678);
        xfer(1'b0, 1'b0, w, got);
        check("t2_wgrant", 32'(w), 0);
        check("t2_wrdata", got, 0);
        bus.req_valid[0] = 1'b0;
        set_req(2, 1'b1, 1'b1, 16'h0020, 32'h0);
        xfer(1'b0, 1'b0, w, got);
        check("t2_rgrant", 32'(w), 2);
        check("t2_rdata", got, 32'h12345678);
        bus.req_valid[2] = 1'b0;

        // All requesters continuously valid from reset
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        prev_done = 0;
        for (int k = 0; k < 8; k++) begin
            xfer(1'b0, 1'b0, w, got);
            check("t3_order", 32'(w), 32'(k % N));
            if (k > 0) check("t3_spacing", 32'(done_cyc - prev_done), 5);
            prev_done = done_cyc;
            set_req(w, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
        bus.req_valid = '0;

        // Timeout with ready stuck low, then a normal grant
        do_reset();
        set_req(2, 1'b1, 1'b1, 16'h0004, 32'h0);
        set_req(3, 1'b1, 1'b0, 16'h0008, 32'hA5A5_5A5A);
        xfer(1'b1, 1'b0, w, got);
        check("t4_tmo_grant", 32'(w), 2);
        bus.req_valid[2] = 1'b0;
        xfer(1'b0, 1'b0, w, got);
        check("t4_next_grant", 32'(w), 3);
        bus.req_valid[3] = 1'b0;

        // Reset while BUSY: no pulse, requester 0 first afterwards
        set_req(3, 1'b1, 1'b1, 16'h0008, 32'h0);
        for (int t = 0; t < 10 && bus.slv_cs !== 1'b1; t++) tick();
        tick();
        reset = 1'b1;
        tick();
        check("t5_cs", 32'(bus.slv_cs), 0);
        check("t5_rsp", 32'({bus.rsp_done, bus.rsp_err}), 0);
        check("t5_rdata", bus.rsp_rdata, 0);
        reset = 1'b0;
        model_reset();
        set_req(0, 1'b1, 1'b1, 16'h0010, 32'h0);
        xfer(1'b0, 1'b0, w, got);
        check("t5_first", 32'(w), 0);
        bus.req_valid[0] = 1'b0;
        xfer(1'b0, 1'b0, w, got);
        check("t5_second", 32'(w), 3);
        bus.req_valid[3] = 1'b0;

        // Requester drops valid and changes address mid-transfer
        set_req(1, 1'b1, 1'b0, 16'h0040, 32'hCAFE_F00D);
        xfer(1'b0, 1'b1, w, got);
        check("t6_grant", 32'(w), 1);
        check("t6_valid_dropped", 32'(bus.req_valid), 0);
        set_req(0, 1'b1, 1'b1, 16'h0040, 32'h0);
        xfer(1'b0, 1'b0, w, got2);
        check("t6_readback", got2, 32'hCAFE_F00D);
        bus.req_valid[0] = 1'b0;

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if (bus.req_valid == '0)
                set_req(int'($urandom_range(0, N - 1)), 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            w2 = model_pick();
            xfer(1'b0, 1'b0, w, got);
            check("rand_grant", 32'(w), 32'(w2));
            if ($urandom_range(0, 1) == 1) set_req(w, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            else bus.req_valid[w] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
